// File: rtl/baccarat_ctrl.sv
// Baccarat dealing controller: sequences the six card-load strobes, applies
// the third-card rules to the datapath scores and drives the win lights.
module baccarat_ctrl (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  // state  | meaning
  // IDLE   | after reset, nothing dealt
  // P1     | loading player card 1
  // D1     | loading dealer card 1
  // P2     | loading player card 2
  // D2     | loading dealer card 2
  // EVAL_P | four cards dealt, decide natural / player draw / dealer draw
  // P3     | loading player card 3
  // EVAL_D | player drew, apply dealer third-card table
  // D3     | loading dealer card 3
  // DONE   | game over, lights follow the live scores
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_EVAL_P = 4'd5,
    S_P3     = 4'd6,
    S_EVAL_D = 4'd7,
    S_D3     = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic       natural;
  logic       dealer_draw;
  logic [3:0] pc3_face;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Tens and court cards (and the "not dealt" code 0) are worth nothing.
  always_comb begin
    natural  = (pscore == 4'd8) || (pscore == 4'd9) ||
               (dscore == 4'd8) || (dscore == 4'd9);
    pc3_face = ((pcard3 >= 4'd1) && (pcard3 <= 4'd9)) ? pcard3 : 4'd0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (pc3_face != 4'd8);
      4'd4:             dealer_draw = (pc3_face >= 4'd2) && (pc3_face <= 4'd7);
      4'd5:             dealer_draw = (pc3_face >= 4'd4) && (pc3_face <= 4'd7);
      4'd6:             dealer_draw = (pc3_face >= 4'd6) && (pc3_face <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = S_P1;
      S_P1:   state_d = S_D1;
      S_D1:   state_d = S_P2;
      S_P2:   state_d = S_D2;
      S_D2:   state_d = S_EVAL_P;
      // Out-of-range scores fall through every test below, i.e. that side stands.
      S_EVAL_P: begin
        if (natural)                state_d = S_DONE;
        else if (pscore <= 4'd5)    state_d = S_P3;
        else if (dscore <= 4'd5)    state_d = S_D3;
        else                        state_d = S_DONE;
      end
      S_P3:     state_d = S_EVAL_D;
      S_EVAL_D: state_d = dealer_draw ? S_D3 : S_DONE;
      S_D3:     state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state_q)
      S_P1: load_pcard1 = 1'b1;
      S_D1: load_dcard1 = 1'b1;
      S_P2: load_pcard2 = 1'b1;
      S_D2: load_dcard2 = 1'b1;
      S_P3: load_pcard3 = 1'b1;
      S_D3: load_dcard3 = 1'b1;
      S_DONE: begin
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Self-checking bench for baccarat_ctrl: directed games, the dealer table
// sweep and random games, all checked against a game-level reference model.
module tb_baccarat_ctrl;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] L_NONE = 6'b000000;
  localparam logic [5:0] L_P1   = 6'b100000;
  localparam logic [5:0] L_D1   = 6'b010000;
  localparam logic [5:0] L_P2   = 6'b001000;
  localparam logic [5:0] L_D2   = 6'b000100;
  localparam logic [5:0] L_P3   = 6'b000010;
  localparam logic [5:0] L_D3   = 6'b000001;

  baccarat_ctrl dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial slow_clock = 1'b0;
  always #20 slow_clock = ~slow_clock;

  function automatic logic [7:0] loads_now();
    return {2'b00, load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  endfunction

  function automatic logic [7:0] lights_now();
    return {6'b0, player_win_light, dealer_win_light};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Dealer third-card rule: row lower bound rises by two per dealer point from 4 up.
  function automatic bit dealer_table(input int d, input int pc);
    int f;
    f = (pc == 0 || pc >= 10) ? 0 : pc;
    if (d <= 2) return 1'b1;
    if (d == 3) return (f != 8);
    if (d <= 6) return (f >= 2 * (d - 3)) && (f <= 7);
    return 1'b0;
  endfunction

  task automatic play(input int ps_e, input int ds_e, input int pc3,
                      input int ps_f, input int ds_f, input int hold, input string tag);
    logic [5:0] seq[$];
    bit nat, pdraw, ddraw;
    int done_at, ps, ds;
    logic [7:0] exp_lights;
    nat   = (ps_e == 8) || (ps_e == 9) || (ds_e == 8) || (ds_e == 9);
    pdraw = !nat && (ps_e <= 5);
    if (pdraw) ddraw = dealer_table(ds_e, pc3);
    else       ddraw = !nat && (ds_e <= 5);
    seq = '{L_P1, L_D1, L_P2, L_D2, L_NONE};
    if (pdraw) begin
      seq.push_back(L_P3);
      seq.push_back(L_NONE);
    end
    if (ddraw) seq.push_back(L_D3);
    done_at = seq.size();

    resetb = 1'b0;
    pscore = 4'(ps_e);
    dscore = 4'(ds_e);
    pcard3 = 4'(pc3);
    repeat (2) @(posedge slow_clock);
    #1;
    chk($sformatf("%s rst_loads", tag), loads_now(), 8'h00);
    chk($sformatf("%s rst_lights", tag), lights_now(), 8'h00);
    @(negedge slow_clock) resetb = 1'b1;
    #1 chk($sformatf("%s idle_loads", tag), loads_now(), 8'h00);

    for (int k = 0; k < done_at + hold; k++) begin
      @(posedge slow_clock);
      #1;
      if (k == done_at) begin
        ps = ps_f;
        ds = ds_f;
      end else if (k > done_at) begin
        ps = int'($urandom_range(0, 9));
        ds = int'($urandom_range(0, 9));
      end else begin
        ps = ps_e;
        ds = ds_e;
      end
      pscore = 4'(ps);
      dscore = 4'(ds);
      @(negedge slow_clock);
      chk($sformatf("%s loads c%0d", tag, k), loads_now(),
          (k < done_at) ? {2'b00, seq[k]} : 8'h00);
      exp_lights = (k < done_at) ? 8'h00 : {6'b0, ps >= ds, ds >= ps};
      chk($sformatf("%s lights c%0d", tag, k), lights_now(), exp_lights);
    end
  endtask

  initial begin
    int ps, ds, pc;
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;

    // Asynchronous reset in the middle of the deal.
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock) resetb = 1'b1;
    #1 chk("mid pre_e0", loads_now(), 8'h00);
    repeat (3) @(posedge slow_clock);
    #5 chk("mid p2_strobe", loads_now(), {2'b00, L_P2});
    #5 resetb = 1'b0;
    #1 chk("mid async_loads", loads_now(), 8'h00);
    chk("mid async_lights", lights_now(), 8'h00);
    repeat (2) @(posedge slow_clock);
    #1 chk("mid held_loads", loads_now(), 8'h00);

    play(8, 3, 0, 8, 3, 3, "nat83");
    play(9, 9, 0, 9, 9, 3, "nat99");
    play(4, 5, 6, 7, 7, 3, "pdraw_ddraw");
    play(3, 6, 5, 2, 6, 3, "pdraw_dstand");
    play(6, 4, 0, 6, 4, 3, "pstand_ddraw");
    play(7, 7, 0, 7, 7, 3, "both_stand");
    play(12, 3, 0, 5, 5, 2, "illegal_p");
    play(2, 11, 4, 4, 2, 2, "illegal_d");
    play(15, 14, 7, 1, 9, 2, "illegal_both");

    // Reset honoured in DONE: lights drop without a clock edge.
    play(8, 8, 0, 8, 8, 1, "tie_done");
    #3;
    pscore = 4'd5;
    dscore = 4'd5;
    #1 chk("done live_tie", lights_now(), 8'h03);
    #2 resetb = 1'b0;
    #1 chk("done async_lights", lights_now(), 8'h00);

    for (int d = 0; d <= 7; d++)
      for (int c = 0; c <= 13; c++)
        play(0, d, c, 0, d, (d == 7 && c == 13) ? 20 : 1, $sformatf("sweep d%0d c%0d", d, c));

    for (int g = 0; g < 150; g++) begin
      ps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      ds = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      pc = int'($urandom_range(0, 13));
      play(ps, ds, pc, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 2,
           $sformatf("rand%0d", g));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baccarat_ctrl.md
Name: baccarat_ctrl

Overview:
- Control FSM for the baccarat game; directly upstream of the datapath.
- Generates the six one-hot card-load strobes in the fixed deal order, reads back pscore/dscore/pcard3, and applies the third-card rules.
- Drives the player/dealer win lights.
- Runs on slow_clock, the same clock the datapath uses to capture cards.

Parameters:
- None.

Ports:
- slow_clock  input  1  system clock; all state changes on posedge.
- resetb  input  1  asynchronous, active-low reset.
- pscore  input  4  player hand score from datapath, 0-9.
- dscore  input  4  dealer hand score from datapath, 0-9.
- pcard3  input  4  player third card value from datapath (0 = not dealt, 1-13 card rank).
- load_pcard1  output  1  load player card 1 on next posedge.
- load_pcard2  output  1  load player card 2.
- load_pcard3  output  1  load player card 3.
- load_dcard1  output  1  load dealer card 1.
- load_dcard2  output  1  load dealer card 2.
- load_dcard3  output  1  load dealer card 3.
- player_win_light  output  1  player wins (or tie).
- dealer_win_light  output  1  dealer wins (or tie).

Behaviour:
- Moore machine. All outputs decode from the state register only, except the lights, which decode from state plus scores.
- At most one load strobe is high in any cycle.
- States: IDLE, P1, D1, P2, D2, EVAL_P, P3, EVAL_D, D3, DONE.
- Reset:
  - resetb=0 forces IDLE immediately (asynchronous).
  - In IDLE, all loads = 0 and both lights = 0.
  - Reset is honoured in any state, including mid-deal and DONE.
- Deal sequence, edges counted from the first posedge after resetb rises:
  - e0: IDLE->P1.
  - e1: pcard1 captured; P1->D1.
  - e2: D1->P2.
  - e3: P2->D2.
  - e4: D2->EVAL_P.
- Load strobe per state: P1 = load_pcard1, D1 = load_dcard1, P2 = load_pcard2, D2 = load_dcard2, P3 = load_pcard3, D3 = load_dcard3. All other states drive no loads.
- EVAL_P (scores reflect four cards), evaluated in priority order:
  - pscore in {8,9} or dscore in {8,9}: ->DONE (natural).
  - Else pscore 0-5: ->P3.
  - Else (pscore 6-7), dscore 0-5: ->D3.
  - Else: ->DONE.
- P3: ->EVAL_D unconditionally.
- EVAL_D (pcard3 is valid). Dealer draws iff the dscore row allows it; draw ->D3, else ->DONE:
  - dscore 0-2: always.
  - dscore 3: pcard3 != 8.
  - dscore 4: pcard3 2-7.
  - dscore 5: pcard3 4-7.
  - dscore 6: pcard3 6-7.
  - dscore 7: never.
  - pcard3 of 0 or 10-13 counts as face value 0 for this table.
- D3: ->DONE unconditionally.
- DONE:
  - Absorbing; stays until resetb=0.
  - player_win_light = (pscore > dscore) or equal.
  - dealer_win_light = (dscore > pscore) or equal.
  - Tie lights both.
  - Lights are combinational from the live scores while in DONE; 0 in every other state.
- Illegal scores 10-15 at EVAL_P/EVAL_D: treated as non-natural and as "stand" (no draw) for that side.
- Unreachable state encodings: ->IDLE on the next edge, all outputs 0.
- Game latency:
  - Natural or both stand: DONE at e5.
  - Player draw only: DONE at e7.
  - Player draw + dealer draw: DONE at e8.
  - Dealer draw only (player stands): DONE at e6.

Test Plan:
- Reset/deal order: hold resetb=0 two edges, release → loads all 0 until e0; then exactly one strobe per cycle in order pcard1, dcard1, pcard2, dcard2 (high in cycles e0-e1 .. e3-e4); resetb=0 asserted between edges at e2+10ns → loads and lights drop to 0 without waiting for a clock edge.
- Natural: at EVAL_P drive pscore=8, dscore=3 → no load_pcard3/load_dcard3 ever, DONE at e5, player_win_light=1, dealer_win_light=0; repeat with pscore=9, dscore=9 → both lights 1.
- Player and dealer draw: pscore=4, dscore=5 → load_pcard3 in e5-e6; with pcard3=6 → load_dcard3 in e7-e8; final pscore=7, dscore=7 → both lights 1 at DONE (e8).
- Dealer stands after player draw: pscore=3, dscore=6, pcard3=5 → load_pcard3 only, DONE at e7; final pscore=2, dscore=6 → dealer_win_light=1, player_win_light=0.
- Player stands: pscore=6, dscore=4 → no load_pcard3, load_dcard3 in e5-e6, DONE at e6; pscore=7, dscore=7 → DONE at e5 with no third cards.
- Table boundaries in EVAL_D: sweep dscore 0-7 against pcard3 0-13 → draw exactly per table (e.g. dscore=3/pcard3=8 → stand; dscore=4/pcard3=1 → stand; dscore=4/pcard3=2 → draw; dscore=7 → always stand); DONE state persists for 20 further edges.
